button_conditioner: RTL and testbench

//  Conditions the four raw board pushbuttons before they reach the MAC-address configuration FSM.
//  Per button: 2-flop synchronizer, debounce, then a one-cycle press pulse.
//  Up/down also auto-repeat while held, so the FSM can step an address value by holding the button.

---
 rtl/button_conditioner.sv | 139 +++++++++++++
 tb/tb_button_conditioner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
//
// Conditions the four raw board pushbuttons before they reach the
// MAC-address configuration FSM. Each button gets a 2-flop synchronizer, a
// debouncer and a one-cycle press pulse. Buttons enabled in REPEAT_MASK also
// auto-repeat while held, so the consumer can step a value by holding a key.
// The four channels are identical and fully independent; several pulses may
// be high in the same cycle and arbitration is left to the consumer.
//
// Auto-repeat states (per channel)
//   state  | meaning
//   IDLE   | no repeat pending; waits for a press pulse
//   DELAY  | button held, counting down the initial repeat delay
//   REPEAT | button held, emitting a pulse every REPEAT_PERIOD cycles
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   btn_*_raw      raw asynchronous pins, active high
//   button_*       one-cycle press pulse, plus repeats where enabled
//   btn_level      debounced levels, bit 0=left 1=right 2=up 3=down

module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 650000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 15000000,
   parameter logic [3:0]  REPEAT_MASK     = 4'b1100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_left_raw,
   input  logic       btn_right_raw,
   input  logic       btn_up_raw,
   input  logic       btn_down_raw,
   output logic       button_left,
   output logic       button_right,
   output logic       button_up,
   output logic       button_down,
   output logic [3:0] btn_level
);

   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_W = $clog2(RPT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   logic [3:0] w_raw;
   logic [3:0] w_pulse;
   logic [3:0] w_level;

   assign w_raw = {btn_down_raw, btn_up_raw, btn_right_raw, btn_left_raw};

   for (genvar i = 0; i < 4; i++) begin : g_ch
      logic             r_s1;
      logic             r_s2;
      logic             r_db;
      logic             r_pulse;
      logic [DB_W-1:0]  r_cnt;
      logic [RPT_W-1:0] r_rpt;
      rpt_state_t       r_state;
      logic             w_press;

      // The edge that accepts a rising level is the edge that emits the press.
      assign w_press = r_s2 && !r_db && (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

      always_ff @(posedge clk) begin
         if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_db    <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
            r_rpt   <= '0;
            r_state <= IDLE;
         end else begin
            r_s1 <= w_raw[i];
            r_s2 <= r_s1;

            // Any sample agreeing with the debounced level restarts the count.
            if (r_s2 == r_db) begin
               r_cnt <= '0;
            end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               r_db  <= r_s2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + DB_W'(1);
            end

            r_pulse <= w_press;

            case (r_state)
               IDLE: begin
                  if (REPEAT_MASK[i] && w_press) begin
                     r_state <= DELAY;
                     r_rpt   <= '0;
                  end
               end
               DELAY: begin
                  if (!r_db) begin
                     r_state <= IDLE;
                  end else if (r_rpt == RPT_W'(REPEAT_DELAY - 1)) begin
                     r_pulse <= 1'b1;
                     r_rpt   <= '0;
                     r_state <= REPEAT;
                  end else begin
                     r_rpt <= r_rpt + RPT_W'(1);
                  end
               end
               REPEAT: begin
                  if (!r_db) begin
                     r_state <= IDLE;
                  end else if (r_rpt == RPT_W'(REPEAT_PERIOD - 1)) begin
                     r_pulse <= 1'b1;
                     r_rpt   <= '0;
                  end else begin
                     r_rpt <= r_rpt + RPT_W'(1);
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end

      assign w_pulse[i] = r_pulse;
      assign w_level[i] = r_db;
   end

   assign button_left  = w_pulse[0];
   assign button_right = w_pulse[1];
   assign button_up    = w_pulse[2];
   assign button_down  = w_pulse[3];
   assign btn_level    = w_level;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 8;
   localparam int RP = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       l_raw = 1'b0, r_raw = 1'b0, u_raw = 1'b0, d_raw = 1'b0;
   logic       button_left, button_right, button_up, button_down;
   logic [3:0] btn_level;

   button_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .REPEAT_MASK    (4'b1100)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_left_raw (l_raw),
      .btn_right_raw(r_raw),
      .btn_up_raw   (u_raw),
      .btn_down_raw (d_raw),
      .button_left  (button_left),
      .button_right (button_right),
      .button_up    (button_up),
      .button_down  (button_down),
      .btn_level    (btn_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [3:0] v;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   down_cnt = 0;

   // Insert an expected pulse vector for edge c, keeping the queue time-ordered.
   function automatic void push(int c, logic [3:0] v);
      int i = 0;
      while (i < q.size() && q[i].c < c) i++;
      if (i < q.size() && q[i].c == c) begin
         q[i].v = q[i].v | v;
      end else begin
         exp_t e;
         e.c = c;
         e.v = v;
         q.insert(i, e);
      end
   endfunction

   // Raw level high for h samples starting at edge e0.
   // Press pulse at e0+D+1; db falls at edge e0+h+D+1; repeats while db still high.
   function automatic void expect_hold(int e0, int h, int idx, bit rep);
      int p = e0 + D + 1;
      int f = e0 + h + D + 1;
      logic [3:0] m = 4'(1 << idx);
      push(p, m);
      if (rep) begin
         for (int k = p + RD; k <= f; k += RP) push(k, m);
      end
   endfunction

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   exp_t       m_e;
   logic [3:0] m_obs;
   logic [3:0] m_exp;

   // Scoreboard: every cycle the pulse vector must match the queued expectation.
   always @(negedge clk) begin
      if (cyc >= 1) begin
         m_exp = 4'b0000;
         if (q.size() > 0 && q[0].c == cyc) begin
            m_e   = q.pop_front();
            m_exp = m_e.v;
         end
         m_obs = {button_down, button_up, button_right, button_left};
         total++;
         assert (m_obs === m_exp) else begin
            bad++;
            $error("FAIL pulse cyc=%0d observed=%b expected=%b", cyc, m_obs, m_exp);
         end
         if (button_down === 1'b1) down_cnt++;
      end
   end

   int c;
   int r0;

   initial begin
      // 1. reset held 10 cycles
      reset = 1'b1;
      tick(3);
      chk("level_in_reset", btn_level, 4'b0000);
      tick(7);
      reset = 1'b0;
      tick(3);
      chk("level_after_reset", btn_level, 4'b0000);

      // 2. left press, hold 20, release
      c = cyc;
      l_raw = 1'b1;
      expect_hold(c + 1, 20, 0, 1'b0);
      tick(5);
      chk("left_level_before_accept", btn_level, 4'b0000);
      tick(1);
      chk("left_level_accepted", btn_level, 4'b0001);
      tick(14);
      l_raw = 1'b0;
      tick(5);
      chk("left_level_still_high", btn_level, 4'b0001);
      tick(1);
      chk("left_level_released", btn_level, 4'b0000);
      tick(4);

      // 3. up bounce then stable
      u_raw = 1'b1; tick(2);
      u_raw = 1'b0; tick(2);
      u_raw = 1'b1; tick(2);
      u_raw = 1'b0; tick(2);
      chk("up_level_bounce", btn_level, 4'b0000);
      c = cyc;
      u_raw = 1'b1;
      expect_hold(c + 1, 16, 2, 1'b1);
      tick(16);
      chk("up_level_held", btn_level, 4'b0100);
      u_raw = 1'b0;
      tick(12);
      chk("up_level_released", btn_level, 4'b0000);

      // 4. down held 30 cycles with auto-repeat
      down_cnt = 0;
      c = cyc;
      d_raw = 1'b1;
      expect_hold(c + 1, 30, 3, 1'b1);
      tick(10);
      chk("down_level_held", btn_level, 4'b1000);
      tick(20);
      d_raw = 1'b0;
      tick(12);
      chk("down_pulse_count", down_cnt, 9);
      chk("down_level_released", btn_level, 4'b0000);

      // 5. right and up together
      c = cyc;
      r_raw = 1'b1;
      u_raw = 1'b1;
      expect_hold(c + 1, 15, 1, 1'b0);
      expect_hold(c + 1, 15, 2, 1'b1);
      tick(15);
      chk("right_up_level", btn_level, 4'b0110);
      r_raw = 1'b0;
      u_raw = 1'b0;
      tick(12);
      chk("right_up_released", btn_level, 4'b0000);

      // 6. up held, reset during DELAY
      c = cyc;
      u_raw = 1'b1;
      push(c + 1 + D + 1, 4'b0100);
      tick(8);
      reset = 1'b1;
      tick(2);
      chk("level_mid_reset", btn_level, 4'b0000);
      reset = 1'b0;
      r0 = cyc + 1;
      expect_hold(r0, 18, 2, 1'b1);
      tick(5);
      chk("level_after_reset_pre", btn_level, 4'b0000);
      tick(13);
      chk("level_after_reset_held", btn_level, 4'b0100);
      u_raw = 1'b0;
      tick(12);
      chk("level_final", btn_level, 4'b0000);

      chk("scoreboard_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
